// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable integer clock divider, CLK_OUT = CLK_IN / N.
// N is taken from a divisor register (2 .. 2^DIV_W-1). Divisor changes and
// run/stop requests only take effect at period boundaries, so CLK_OUT never
// shows a runt pulse.
//
// Ports:
//   CLK_IN   source clock
//   RST      asynchronous active-low reset
//   EN       run request (level)
//   DIV_SEL  new divisor value
//   DIV_LOAD one-cycle strobe capturing DIV_SEL into the pending slot
//   CLK_OUT  divided clock
//   TICK     one-cycle strobe at each CLK_OUT rising edge
//   DIV_ACK  one-cycle strobe when a pending divisor is applied
//   DIV_ERR  one-cycle strobe when a load carried DIV_SEL < 2 (discarded)
//
// Optional: define CLK_DIV_ODD_DUTY50_EN to add a negedge stage that
// stretches the high phase by half a cycle for odd N (exact 50% duty).
module clk_div_prog #(
    parameter int unsigned DIV_W   = 8,
    parameter int unsigned DIV_RST = 2
) (
    input  logic             CLK_IN,
    input  logic             RST,
    input  logic             EN,
    input  logic [DIV_W-1:0] DIV_SEL,
    input  logic             DIV_LOAD,
    output logic             CLK_OUT,
    output logic             TICK,
    output logic             DIV_ACK,
    output logic             DIV_ERR
);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t           state, state_n;
    logic [DIV_W-1:0] cnt, cnt_n;
    logic [DIV_W-1:0] div_q, div_n;
    logic [DIV_W-1:0] pend, pend_n;
    logic             pend_v, pend_v_n;
    logic             pos_q, pos_n;
    logic             tick_n, ack_n, err_n;
    logic             wrap_c, load_ok_c, apply_c;

    // State and registered outputs
    always_ff @(posedge CLK_IN or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            cnt     <= '0;
            div_q   <= DIV_W'(DIV_RST);
            pend    <= '0;
            pend_v  <= 1'b0;
            pos_q   <= 1'b0;
            TICK    <= 1'b0;
            DIV_ACK <= 1'b0;
            DIV_ERR <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            div_q   <= div_n;
            pend    <= pend_n;
            pend_v  <= pend_v_n;
            pos_q   <= pos_n;
            TICK    <= tick_n;
            DIV_ACK <= ack_n;
            DIV_ERR <= err_n;
        end
    end

    // Next state, counter, divisor bookkeeping and output decode
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        div_n     = div_q;
        pend_n    = pend;
        pend_v_n  = pend_v;
        pos_n     = 1'b0;
        tick_n    = 1'b0;
        ack_n     = 1'b0;
        apply_c   = 1'b0;
        wrap_c    = (cnt == div_q - DIV_W'(1));
        load_ok_c = DIV_LOAD && (DIV_SEL >= DIV_W'(2));
        err_n     = DIV_LOAD && !load_ok_c;

        case (state)
            IDLE: begin
                cnt_n   = '0;
                apply_c = pend_v;
                if (EN) state_n = RUN;
            end
            RUN, STOP: begin
                if (wrap_c) begin
                    // Period boundary: the only point where N or run state may change
                    cnt_n   = '0;
                    apply_c = pend_v;
                    state_n = EN ? RUN : IDLE;
                end else begin
                    cnt_n   = cnt + DIV_W'(1);
                    state_n = EN ? RUN : STOP;
                end
            end
            default: state_n = IDLE;
        endcase

        if (apply_c) begin
            div_n    = pend;
            pend_v_n = 1'b0;
            ack_n    = 1'b1;
        end

        // A load at the apply edge only refills the pending slot
        if (load_ok_c) begin
            pend_n   = DIV_SEL;
            pend_v_n = 1'b1;
        end

        // New period uses the divisor valid after this edge
        pos_n  = (state_n != IDLE) && (cnt_n < (div_n >> 1));
        tick_n = (state_n != IDLE) && (cnt_n == '0);
    end

`ifdef CLK_DIV_ODD_DUTY50_EN
    logic neg_q;

    // Half-cycle delayed copy of the high phase, only for odd N
    always_ff @(negedge CLK_IN or negedge RST) begin
        if (!RST) neg_q <= 1'b0;
        else      neg_q <= pos_q & div_q[0];
    end

    assign CLK_OUT = pos_q | neg_q;
`else
    assign CLK_OUT = pos_q;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: scoreboard bench for clk_div_prog. A cycle model predicts
// {CLK_OUT, TICK, DIV_ACK, DIV_ERR} for every driven cycle; predictions are
// queued at drive time and compared after the following CLK_IN rising edge.
module tb_clk_div_prog;

    localparam int unsigned DIV_W = 8;

    logic             CLK_IN = 1'b0;
    logic             RST    = 1'b1;
    logic             EN     = 1'b0;
    logic [DIV_W-1:0] DIV_SEL = '0;
    logic             DIV_LOAD = 1'b0;
    logic             CLK_OUT, TICK, DIV_ACK, DIV_ERR;

    clk_div_prog #(.DIV_W(DIV_W), .DIV_RST(2)) dut (
        .CLK_IN   (CLK_IN),
        .RST      (RST),
        .EN       (EN),
        .DIV_SEL  (DIV_SEL),
        .DIV_LOAD (DIV_LOAD),
        .CLK_OUT  (CLK_OUT),
        .TICK     (TICK),
        .DIV_ACK  (DIV_ACK),
        .DIV_ERR  (DIV_ERR)
    );

    always #5 CLK_IN = ~CLK_IN;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int tick_seen = 0;
    int ack_seen  = 0;

    logic [3:0] exp_q[$];

    // Model state: active flag, phase within the period, divisor, pending slot
    int m_n, m_pend, m_phase;
    bit m_act, m_pend_v;
    bit p_pos, p_odd;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n = 2; m_pend = 0; m_pend_v = 0;
        m_act = 0; m_phase = 0; p_pos = 0; p_odd = 0;
        exp_q.delete();
    endtask

    task automatic step(input bit en, input bit ld, input int sel);
        logic [3:0] e;
        logic [3:0] got;
        bit pos, tk, ak, er, ld_ok;
        EN = en; DIV_LOAD = ld; DIV_SEL = DIV_W'(sel);
        ld_ok = ld && (sel >= 2);
        er = ld && !ld_ok;
        tk = 0; ak = 0;
        if (!m_act) begin
            if (m_pend_v) begin m_n = m_pend; m_pend_v = 0; ak = 1; end
            if (en) begin m_act = 1; m_phase = 0; tk = 1; end
        end else if (m_phase == m_n - 1) begin
            if (m_pend_v) begin m_n = m_pend; m_pend_v = 0; ak = 1; end
            m_phase = 0;
            if (en) tk = 1;
            else    m_act = 0;
        end else begin
            m_phase++;
        end
        if (ld_ok) begin m_pend = sel; m_pend_v = 1; end
        pos = m_act && (m_phase < m_n / 2);
`ifdef CLK_DIV_ODD_DUTY50_EN
        e = {pos | (p_pos & p_odd), tk, ak, er};
`else
        e = {pos, tk, ak, er};
`endif
        p_pos = pos;
        p_odd = (m_n % 2) == 1;
        exp_q.push_back(e);

        @(posedge CLK_IN);
        #1;
        got = {CLK_OUT, TICK, DIV_ACK, DIV_ERR};
        if (TICK)    tick_seen++;
        if (DIV_ACK) ack_seen++;
        if (exp_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
        else chk($sformatf("cyc%0d_out", cyc), 32'(got), 32'(exp_q.pop_front()));
        cyc++;
    endtask

    // Advance (loads idle) until the model sits at the given divisor and phase
    task automatic run_until(input int n, input int ph);
        for (int k = 0; k < 64 && !(m_act && m_n == n && m_phase == ph); k++)
            step(1, 0, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin : main
        int a0, t0, hi;
        model_reset();
        #2 RST = 1'b0;
        #1 chk("rst_out", 32'({CLK_OUT, TICK, DIV_ACK, DIV_ERR}), 32'd0);
        @(negedge CLK_IN) RST = 1'b1;

        // Divide-by-2 from reset, then async reset mid-run
        for (int i = 0; i < 7; i++) step(1, 0, 0);
        #2 RST = 1'b0;
        #1 chk("midrst_out", 32'({CLK_OUT, TICK, DIV_ACK, DIV_ERR}), 32'd0);
        model_reset();
        EN = 1'b0;
        @(negedge CLK_IN) RST = 1'b1;

        // Load 6 while idle, then run
        a0 = ack_seen;
        step(0, 1, 6);
        step(0, 0, 0);
        for (int i = 0; i < 14; i++) step(1, 0, 0);
        chk("n6_ack_once", 32'(ack_seen - a0), 32'd1);

        // Switch to 4, then load 10 at cnt=1
        step(1, 1, 4);
        run_until(4, 1);
        a0 = ack_seen;
        step(1, 1, 10);
        step(1, 0, 0);
        step(1, 0, 0);
        hi = 0; t0 = tick_seen;
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0);
            hi += int'(CLK_OUT);
        end
        chk("n10_ack_once", 32'(ack_seen - a0), 32'd1);
        chk("n10_high5", 32'(hi), 32'd5);
        chk("n10_one_tick", 32'(tick_seen - t0), 32'd1);

        // Odd divisor 5
        step(1, 1, 5);
        run_until(5, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 0);

        // N=8, drop EN at cnt=2: finish the period, idle, no tick; re-enable
        step(1, 1, 8);
        run_until(8, 2);
        t0 = tick_seen;
        for (int i = 0; i < 8; i++) step(0, 0, 0);
        chk("stop_no_tick", 32'(tick_seen - t0), 32'd0);
        chk("stop_clk_low", 32'(CLK_OUT), 32'd0);
        step(1, 0, 0);
        chk("reen_tick", 32'(TICK), 32'd1);

        // Illegal divisor, then two loads in one period (last wins)
        step(1, 1, 1);
        chk("err_pulse", 32'(DIV_ERR), 32'd1);
        run_until(8, 1);
        a0 = ack_seen;
        step(1, 1, 7);
        step(1, 1, 9);
        for (int i = 0; i < 16; i++) step(1, 0, 0);
        chk("two_loads_ack_once", 32'(ack_seen - a0), 32'd1);

        // Load on a wrap edge with nothing pending: applied one wrap later
        run_until(9, 8);
        step(1, 1, 3);
        for (int i = 0; i < 12; i++) step(1, 0, 0);

        // Load on a wrap edge while another value is pending
        run_until(3, 1);
        step(1, 1, 6);
        step(1, 1, 4);
        for (int i = 0; i < 14; i++) step(1, 0, 0);

        // Random mix of run/stop, loads and illegal values
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0,
                 int'($urandom_range(0, 12)));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Programmable integer clock divider: derives CLK_OUT = CLK_IN / N, with N runtime-selectable from 2 to 2^DIV_W-1.
- Provides glitch-free ratio changes and glitch-free start/stop gating.
- Outputs a single-cycle TICK strobe, synchronous to CLK_IN, marking each CLK_OUT period start.
- Replaces fixed divide-by-2 instances in the serial/parallel clocking path wherever several bit-clock rates are needed.

Parameters:
- DIV_W, 8, width of the divisor register and of the period counter.
- DIV_RST, 2, divisor loaded at reset; must be in the range 2..2^DIV_W-1.

Ports:
- CLK_IN  input  1  source clock; all logic is posedge except the optional negedge stage.
- RST  input  1  asynchronous, active-low reset.
- EN  input  1  run request; level-sensitive.
- DIV_SEL  input  DIV_W  new divisor value N.
- DIV_LOAD  input  1  one-cycle strobe that captures DIV_SEL.
- CLK_OUT  output  1  divided clock.
- TICK  output  1  one CLK_IN-cycle pulse coinciding with each CLK_OUT rising edge.
- DIV_ACK  output  1  one-cycle pulse when a pending divisor takes effect.
- DIV_ERR  output  1  one-cycle pulse when DIV_LOAD carries DIV_SEL < 2; that value is discarded.

Behaviour:
- Reset (RST=0, async):
  - state=IDLE, cnt=0, div_q=DIV_RST, pend_v=0.
  - CLK_OUT=0, TICK=0, DIV_ACK=0, DIV_ERR=0.
- All outputs are registered.
- Definitions: N=div_q, H=floor(N/2).
- State IDLE:
  - cnt=0, CLK_OUT=0.
  - EN sampled 1 at edge k → at edge k: state=RUN, cnt=0, CLK_OUT=1, TICK=1.
- State RUN, each edge:
  - cnt <= (cnt==N-1) ? 0 : cnt+1.
  - CLK_OUT is 1 while the new cnt < H, else 0.
  - TICK=1 exactly when the new cnt==0.
  - Result: high for H cycles, low for N-H cycles.
  - N=2 gives a toggle on every edge, identical to the fixed divide-by-2 block.
- EN deasserts in RUN → state=STOP.
  - Counting continues until the edge where cnt would wrap to 0; at that edge state=IDLE, cnt=0, CLK_OUT=0, and no TICK is issued.
  - The final period is therefore never truncated and no runt pulse is produced.
- EN reasserts during STOP → return to RUN with no phase disturbance.
- Divisor load:
  - DIV_LOAD=1 with DIV_SEL>=2 → pend=DIV_SEL, pend_v=1.
  - A later load before application overwrites pend (last wins).
  - DIV_LOAD=1 with DIV_SEL<2 → DIV_ERR pulse next cycle; pend and pend_v unchanged.
- Divisor application:
  - In RUN/STOP: applied at the wrap edge (cnt==N-1 → 0). At that edge div_q=pend, pend_v=0, DIV_ACK=1. The new period starting at that edge already uses the new N.
  - In IDLE: applied on the edge after the load; DIV_ACK pulses.
- DIV_LOAD coinciding with a wrap edge:
  - The strobe is captured into pend only.
  - It is applied at the following wrap, or at the previously pending value's wrap if one was already pending.
- Reset mid-operation: immediate return to reset values; pend is lost.

Optional Feature:
- Macro: CLK_DIV_ODD_DUTY50_EN.
- Defined:
  - A negedge CLK_IN flop (async-reset to 0) samples the posedge output.
  - For odd N, CLK_OUT = pos_q | neg_q, giving a high time of H+0.5 cycles, i.e. exactly 50% duty.
  - For even N, neg_q is forced to 0 and behaviour is unchanged.
  - In STOP/IDLE the OR remains glitch-free because pos_q falls before neg_q.
- Undefined: odd N runs at H/N duty; no negedge logic is synthesised.

Test Plan:
- Reset then EN=1, DIV_RST=2: CLK_OUT toggles every CLK_IN edge, TICK on every 2nd cycle; RST=0 mid-run → CLK_OUT=0 immediately.
- DIV_SEL=6 loaded in IDLE, EN=1: CLK_OUT high for 3 cycles, low for 3, period 6; DIV_ACK exactly once.
- Running at N=4, load N=10 at cnt=1: current period finishes in 4 cycles; DIV_ACK at the wrap; next period is 5 high + 5 low.
- N=5, macro undefined: 2 high / 3 low; macro defined: high 2.5 cycles, low 2.5.
- EN dropped at cnt=2 of N=8: 5 more edges, then CLK_OUT=0 in IDLE; no TICK; re-enable gives TICK on the first edge.
- DIV_LOAD with DIV_SEL=1: DIV_ERR pulse, div_q unchanged; two loads (7 then 9) in one period: only 9 is applied, single DIV_ACK.
